csr_rmw_sequencer: RTL
======================

// Module: csr_rmw_sequencer
// PURPOSE
//  Issue stage for Zicsr instructions, sitting between decode and the CSR file.
//  Accepts one decoded CSR instruction, reads the addressed CSR, and computes the new value (RW/RS/RC, reg or uimm source).
//  Writes that value back, then returns the old value plus any exception to writeback.
//  One instruction in flight; the pipeline stalls on req_ready.
// PARAMETERS
//  XLEN        32  data width (matches arch_reg)
//  CSR_ADDR_W  12  CSR address width
//  REG_IDX_W   5   register index / uimm width
// PORTS
//  clock            in   1          system clock
//  reset_n          in   1          reset, asynchronous, active-low
//  flush            in   1          pipeline flush; aborts the in-flight instruction
//  req_valid        in   1          decoded CSR instruction valid
//  req_ready        out  1          sequencer can accept
//  req_funct3       in   3          Zicsr funct3
//  req_addr         in   CSR_ADDR_W CSR address (instr[31:20])
//  req_rs1_idx      in   REG_IDX_W  rs1 index; the uimm for funct3[2]=1
//  req_rs1_val      in   XLEN       rs1 value
//  req_rd_idx       in   REG_IDX_W  destination register
//  csr_params       out  csr_params_t  read_enable/write_enable/addr to the CSR file
//  csr_reg_in       out  XLEN       value to be written into the CSR
//  csr_read_value   in   XLEN       combinational read data from the CSR file
//  csr_illegal      in   1          CSR file illegal_instr_exception
//  rsp_valid        out  1          result valid
//  rsp_ready        in   1          writeback accepts
//  rsp_rd_idx       out  REG_IDX_W  destination register
//  rsp_rd_we        out  1          write rd (0 if rd==x0 or exception)
//  rsp_rd_value     out  XLEN       old CSR value
//  rsp_exception    out  1          illegal-instruction trap
// BEHAVIOUR
//  - States: IDLE, READ, WRITE, RESP.
//  - Reset: state=IDLE; all outputs 0 except req_ready=1.
//  - IDLE: req_ready=1. On req_valid, latch the request and go to READ. funct3 000/100: latch with exception set, go to RESP.
//  - READ: read_enable=1, addr=latched addr.
//    - Register old=csr_read_value and ill=csr_illegal.
//    - ro_viol = (addr[11:10]==2'b11) && write_needed.
//    - Next state: ill|ro_viol -> RESP with exception; else write_needed -> WRITE; else RESP.
//  - WRITE: write_enable=1, csr_reg_in=new value, then go to RESP.
//  - RESP: rsp_valid=1, outputs held stable until rsp_ready, then go to IDLE.
//  - Latency: accept at cycle N; write_enable at N+2; rsp_valid at N+3 (N+2 when the write is skipped).
//  - src = funct3[2] ? zero-extended rs1_idx : rs1_val.
//  - new value: RW -> src; RS -> old|src; RC -> old&~src. Computed from the registered old value.
//  - rsp_rd_we = !exception && rd_idx!=0.
//  - rsp_rd_value = old on success, 0 on exception.
//  - flush, any state: return to IDLE with no rsp. In WRITE, write_enable is gated low combinationally in the same cycle.
//  - Simultaneous flush and req_valid in IDLE: the request is not accepted.
//  - reset_n low mid-operation: outputs drop immediately; no partial write occurs.
// CONFIGURATION
//  CSR_SIDE_EFFECT_SUPPRESS_EN
//  - Defined: RS/RC/RSI/RCI with a zero source (rs1_idx==0 or uimm==0) set write_needed=0.
//    - WRITE is skipped.
//    - Read-only CSRs are readable without an exception.
//  - Undefined: write_needed=1 for every legal funct3. Any RS/RC to addr[11:10]==11 traps.
// STRUCTURE
//  - csr_pkg gains:
//    - csr_op_t enum {CSR_OP_RW, CSR_OP_RS, CSR_OP_RC}
//    - csr_seq_state_t
//    - CSR_F3_* localparams
//    - CSR_RO_PREFIX = 2'b11
//  - Sub-module csr_op_alu: combinational (op, old, src) -> new value.
// TESTING
//  - CSRRW 0x340, rs1_val=0xDEADBEEF, CSR reads 0x12345678 -> write_enable at N+2 with reg_in=0xDEADBEEF; rsp at N+3, rd_value=0x12345678.
//  - CSRRS old=0x0F0F0000, src=0x000000FF -> reg_in=0x0F0F00FF. CSRRCI uimm=5, old=0xF -> reg_in=0xA.
//  - CSRRW to 0xC00 -> no write_enable, rsp_exception=1, rd_we=0.
//    CSRRS x0 to 0xC00 -> macro on: rd_value=read, no trap; macro off: trap.
//  - csr_illegal=1 in READ, and funct3=100 -> rsp_exception=1, no write_enable, rd_we=0.
//  - rsp_ready held low 3 cycles -> rsp fields stable, req_ready=0. New req accepted the cycle after handshake.
//  - flush in WRITE -> write_enable=0 that cycle, no rsp. reset_n low in WRITE -> write_enable=0 immediately, state IDLE.

Source files
------------

// File: rtl/csr_pkg.sv
// Shared types and constants for the Zicsr issue sequencer.
package csr_pkg;

   localparam int CSR_PKG_ADDR_W = 12;

   localparam logic [2:0] CSR_F3_CSRRW  = 3'b001;
   localparam logic [2:0] CSR_F3_CSRRS  = 3'b010;
   localparam logic [2:0] CSR_F3_CSRRC  = 3'b011;
   localparam logic [2:0] CSR_F3_CSRRWI = 3'b101;
   localparam logic [2:0] CSR_F3_CSRRSI = 3'b110;
   localparam logic [2:0] CSR_F3_CSRRCI = 3'b111;

   localparam logic [1:0] CSR_RO_PREFIX = 2'b11;

   typedef enum logic [1:0] {
      CSR_OP_RW,
      CSR_OP_RS,
      CSR_OP_RC
   } csr_op_t;

   typedef enum logic [1:0] {
      CSR_SEQ_IDLE,
      CSR_SEQ_READ,
      CSR_SEQ_WRITE,
      CSR_SEQ_RESP
   } csr_seq_state_t;

   typedef struct packed {
      logic                      read_enable;
      logic                      write_enable;
      logic [CSR_PKG_ADDR_W-1:0] addr;
   } csr_params_t;

   // funct3[1:0] selects the operation; funct3[2] only selects the uimm source.
   function automatic csr_op_t f3_to_op(input logic [2:0] f3);
      case (f3[1:0])
         2'b10:   return CSR_OP_RS;
         2'b11:   return CSR_OP_RC;
         default: return CSR_OP_RW;
      endcase
   endfunction

   function automatic logic f3_is_illegal(input logic [2:0] f3);
      return f3[1:0] == 2'b00;
   endfunction

endpackage

// File: rtl/csr_op_alu.sv
// Combinational Zicsr new-value computation: RW writes src, RS sets bits, RC clears bits.
module csr_op_alu
   import csr_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  csr_op_t          op,
   input  logic [XLEN-1:0]  old_value,
   input  logic [XLEN-1:0]  src_value,
   output logic [XLEN-1:0]  new_value
);

   // NOTE: assigning a default before the case keeps every path driven, so no latch is inferred.
   always_comb begin
      new_value = src_value;
      case (op)
         CSR_OP_RS: new_value = old_value | src_value;
         CSR_OP_RC: new_value = old_value & ~src_value;
         default:   new_value = src_value;
      endcase
   end

endmodule

// File: rtl/csr_rmw_sequencer.sv
// Zicsr issue stage: read CSR, optionally write the modified value, return old value to writeback.
// Optional feature macro: CSR_SIDE_EFFECT_SUPPRESS_EN (zero-source RS/RC skips the write).
module csr_rmw_sequencer
   import csr_pkg::*;
#(
   parameter int XLEN       = 32,
   parameter int CSR_ADDR_W = 12,
   parameter int REG_IDX_W  = 5
) (
   input  logic                  clock,
   input  logic                  reset_n,
   input  logic                  flush,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic [2:0]            req_funct3,
   input  logic [CSR_ADDR_W-1:0] req_addr,
   input  logic [REG_IDX_W-1:0]  req_rs1_idx,
   input  logic [XLEN-1:0]       req_rs1_val,
   input  logic [REG_IDX_W-1:0]  req_rd_idx,
   output csr_params_t           csr_params,
   output logic [XLEN-1:0]       csr_reg_in,
   input  logic [XLEN-1:0]       csr_read_value,
   input  logic                  csr_illegal,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output logic [REG_IDX_W-1:0]  rsp_rd_idx,
   output logic                  rsp_rd_we,
   output logic [XLEN-1:0]       rsp_rd_value,
   output logic                  rsp_exception
);

   csr_seq_state_t        r_state;
   csr_seq_state_t        w_next_state;
   logic [CSR_ADDR_W-1:0] r_addr;
   csr_op_t               r_op;
   logic                  r_imm;
   logic [REG_IDX_W-1:0]  r_rs1_idx;
   logic [XLEN-1:0]       r_rs1_val;
   logic [REG_IDX_W-1:0]  r_rd_idx;
   logic [XLEN-1:0]       r_old;
   logic                  r_exc;

   logic                  w_accept;
   logic [XLEN-1:0]       w_src;
   logic [XLEN-1:0]       w_new;
   logic                  w_write_needed;
   logic                  w_ro_viol;
   logic                  w_in_resp;

   assign w_accept  = (r_state == CSR_SEQ_IDLE) && req_valid && !flush;
   assign w_src     = r_imm ? XLEN'(r_rs1_idx) : r_rs1_val;
   assign w_in_resp = (r_state == CSR_SEQ_RESP);

`ifdef CSR_SIDE_EFFECT_SUPPRESS_EN
   // A zero mask (x0 or uimm 0) makes RS/RC pure reads, so read-only CSRs stay readable.
   assign w_write_needed = (r_op == CSR_OP_RW) || (r_rs1_idx != '0);
`else
   assign w_write_needed = 1'b1;
`endif

   assign w_ro_viol = (r_addr[CSR_ADDR_W-1 -: 2] == CSR_RO_PREFIX) && w_write_needed;

   csr_op_alu #(.XLEN(XLEN)) u_alu (
      .op        (r_op),
      .old_value (r_old),
      .src_value (w_src),
      .new_value (w_new)
   );

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= CSR_SEQ_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // NOTE: the request registers are reset too; they are small and keep outputs deterministic.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         r_addr    <= '0;
         r_op      <= CSR_OP_RW;
         r_imm     <= 1'b0;
         r_rs1_idx <= '0;
         r_rs1_val <= '0;
         r_rd_idx  <= '0;
         r_old     <= '0;
         r_exc     <= 1'b0;
      end else if (w_accept) begin
         r_addr    <= req_addr;
         r_op      <= f3_to_op(req_funct3);
         r_imm     <= req_funct3[2];
         r_rs1_idx <= req_rs1_idx;
         r_rs1_val <= req_rs1_val;
         r_rd_idx  <= req_rd_idx;
         r_old     <= '0;
         r_exc     <= f3_is_illegal(req_funct3);
      end else if (r_state == CSR_SEQ_READ) begin
         r_old <= csr_read_value;
         r_exc <= csr_illegal | w_ro_viol;
      end
   end

   always_comb begin
      w_next_state = r_state;
      case (r_state)
         CSR_SEQ_IDLE: begin
            if (w_accept) begin
               w_next_state = f3_is_illegal(req_funct3) ? CSR_SEQ_RESP : CSR_SEQ_READ;
            end
         end
         CSR_SEQ_READ: begin
            if (csr_illegal || w_ro_viol) begin
               w_next_state = CSR_SEQ_RESP;
            end else if (w_write_needed) begin
               w_next_state = CSR_SEQ_WRITE;
            end else begin
               w_next_state = CSR_SEQ_RESP;
            end
         end
         CSR_SEQ_WRITE: w_next_state = CSR_SEQ_RESP;
         CSR_SEQ_RESP: begin
            if (rsp_ready) begin
               w_next_state = CSR_SEQ_IDLE;
            end
         end
         default: w_next_state = CSR_SEQ_IDLE;
      endcase
      if (flush) begin
         w_next_state = CSR_SEQ_IDLE;
      end
   end

   // Outputs decode purely from state, so an async reset drops them without waiting for a clock.
   always_comb begin
      req_ready               = (r_state == CSR_SEQ_IDLE);
      csr_params              = '0;
      csr_params.read_enable  = (r_state == CSR_SEQ_READ);
      csr_params.write_enable = (r_state == CSR_SEQ_WRITE) && !flush;
      if ((r_state == CSR_SEQ_READ) || (r_state == CSR_SEQ_WRITE)) begin
         csr_params.addr = r_addr;
      end
      csr_reg_in    = (r_state == CSR_SEQ_WRITE) ? w_new : '0;
      rsp_valid     = w_in_resp && !flush;
      rsp_rd_idx    = w_in_resp ? r_rd_idx : '0;
      rsp_rd_we     = w_in_resp && !r_exc && (r_rd_idx != '0);
      rsp_rd_value  = (w_in_resp && !r_exc) ? r_old : '0;
      rsp_exception = w_in_resp && r_exc;
   end

endmodule
